// File: rtl/pipeline_control.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, redirect, mul/div occupancy, dmem wait with timeout.
// Latency: stall/flush/redirect/go are combinational from inputs + FSM state; bus_error is registered (1 cycle).
// Backpressure: a pending dmem access freezes IF..MEM; an in-flight mul/div freezes IF..EX and bubbles MEM.
module pipeline_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_addr_decode,
  input  logic [4:0]       rs2_addr_decode,
  input  logic             rs1_used_decode,
  input  logic             rs2_used_decode,
  input  logic [4:0]       rd_addr_execute,
  input  logic             mem_read_execute,
  input  logic             branch_taken_execute,
  input  logic             muldiv_req_execute,
  input  logic             muldiv_done,
  input  logic             dmem_req_mem,
  input  logic             dmem_ack,
  output logic             stall_fetch,
  output logic             stall_decode,
  output logic             stall_execute,
  output logic             stall_mem,
  output logic             flush_decode,
  output logic             flush_execute,
  output logic             flush_mem,
  output logic             flush_wb,
  output logic             pc_redirect,
  output logic             muldiv_go,
  output logic             bus_error,
  output logic [CNT_W-1:0] perf_stall_cycles
);

  // Wide enough to hold MEM_TIMEOUT-1 without wrapping.
  localparam int TW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {MEM_IDLE, MEM_WAIT} mem_state_e;
  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

  mem_state_e       mem_state_q, mem_state_d;
  md_state_e        md_state_q, md_state_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             bus_error_q, bus_error_d;
  logic [CNT_W-1:0] perf_q, perf_d;

  logic timeout;
  logic mem_stall;
  logic md_stall;
  logic load_use;

  // Memory wait FSM: tracks how long the MEM access has been waiting and abandons it at the limit.
  always_comb begin
    mem_state_d = mem_state_q;
    tcnt_d      = tcnt_q;
    timeout     = (mem_state_q == MEM_WAIT) && (tcnt_q == TW'(MEM_TIMEOUT - 1));
    mem_stall   = dmem_req_mem && !dmem_ack && !timeout;
    // Only a genuinely unanswered access counts as an error; a late ack on the last cycle still wins.
    bus_error_d = timeout && dmem_req_mem && !dmem_ack;
    case (mem_state_q)
      MEM_IDLE: begin
        if (mem_stall) begin
          mem_state_d = MEM_WAIT;
          tcnt_d      = TW'(1);
        end
      end
      MEM_WAIT: begin
        if (mem_stall) begin
          tcnt_d = tcnt_q + TW'(1);
        end else begin
          // Ack, timeout, or the request going away all end the wait.
          mem_state_d = MEM_IDLE;
          tcnt_d      = '0;
        end
      end
      default: begin
        mem_state_d = MEM_IDLE;
        tcnt_d      = '0;
      end
    endcase
  end

  // Mul/div FSM: one launch pulse per instruction, then hold EX until the unit reports done.
  always_comb begin
    md_state_d = md_state_q;
    muldiv_go  = 1'b0;
    case (md_state_q)
      MD_IDLE: begin
        // Launch is held off while MEM is frozen so the op is not started twice.
        muldiv_go = muldiv_req_execute && !mem_stall;
        if (muldiv_go && !muldiv_done) begin
          md_state_d = MD_BUSY;
        end
      end
      MD_BUSY: begin
        // done is consumed here even if a MEM stall masks the mul/div outputs.
        if (muldiv_done) begin
          md_state_d = MD_IDLE;
        end
      end
      default: md_state_d = MD_IDLE;
    endcase
    md_stall = (muldiv_go || (md_state_q == MD_BUSY)) && !muldiv_done;
  end

  // Load-use detection: x0 is never a real dependence.
  always_comb begin
    load_use = mem_read_execute && (rd_addr_execute != 5'd0) &&
               ((rs1_used_decode && (rs1_addr_decode == rd_addr_execute)) ||
                (rs2_used_decode && (rs2_addr_decode == rd_addr_execute)));
  end

  // Hazard priority: mem wait > mul/div > taken branch > load-use.
  always_comb begin
    stall_fetch   = 1'b0;
    stall_decode  = 1'b0;
    stall_execute = 1'b0;
    stall_mem     = 1'b0;
    flush_decode  = 1'b0;
    flush_execute = 1'b0;
    flush_mem     = 1'b0;
    flush_wb      = 1'b0;
    pc_redirect   = 1'b0;
    if (mem_stall) begin
      stall_fetch   = 1'b1;
      stall_decode  = 1'b1;
      stall_execute = 1'b1;
      stall_mem     = 1'b1;
      flush_wb      = 1'b1;
    end else if (md_stall) begin
      stall_fetch   = 1'b1;
      stall_decode  = 1'b1;
      stall_execute = 1'b1;
      flush_mem     = 1'b1;
    end else if (branch_taken_execute) begin
      // The ID instruction is wrong-path, so any load-use on it is moot.
      pc_redirect   = 1'b1;
      flush_decode  = 1'b1;
      flush_execute = 1'b1;
    end else if (load_use) begin
      stall_fetch   = 1'b1;
      stall_decode  = 1'b1;
      flush_execute = 1'b1;
    end
  end

  // Saturating count of front-end stall cycles.
  always_comb begin
    perf_d = perf_q;
    if (stall_fetch && !(&perf_q)) begin
      perf_d = perf_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_state_q <= MEM_IDLE;
      md_state_q  <= MD_IDLE;
      tcnt_q      <= '0;
      bus_error_q <= 1'b0;
      perf_q      <= '0;
    end else begin
      mem_state_q <= mem_state_d;
      md_state_q  <= md_state_d;
      tcnt_q      <= tcnt_d;
      bus_error_q <= bus_error_d;
      perf_q      <= perf_d;
    end
  end

  assign bus_error         = bus_error_q;
  assign perf_stall_cycles = perf_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Bench for pipeline_control: vector table plus generated timeout/reset sequences.
// Each vector is one clock cycle; expected outputs are queued when driven and checked mid-cycle.
// perf_stall_cycles is checked every cycle against a bench-side running count.
module tb_pipeline_control;

  localparam int CNT_W = 32;

  // Expected output bits: SF SD SE SM FD FE FM FW PR GO BE
  localparam logic [10:0] E_NONE = 11'b000_0_000_0_0_0_0;
  localparam logic [10:0] E_LU   = 11'b110_0_010_0_0_0_0;
  localparam logic [10:0] E_BR   = 11'b000_0_110_0_1_0_0;
  localparam logic [10:0] E_MDGO = 11'b111_0_001_0_0_1_0;
  localparam logic [10:0] E_MD   = 11'b111_0_001_0_0_0_0;
  localparam logic [10:0] E_MEM  = 11'b111_1_000_1_0_0_0;
  localparam logic [10:0] E_GO   = 11'b000_0_000_0_0_1_0;
  localparam logic [10:0] E_BE   = 11'b000_0_000_0_0_0_1;

  typedef struct {
    logic        rst;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        lr;
    logic        br;
    logic        mreq;
    logic        mdone;
    logic        dreq;
    logic        dack;
    logic [10:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1_addr_decode, rs2_addr_decode, rd_addr_execute;
  logic rs1_used_decode, rs2_used_decode, mem_read_execute, branch_taken_execute;
  logic muldiv_req_execute, muldiv_done, dmem_req_mem, dmem_ack;
  logic stall_fetch, stall_decode, stall_execute, stall_mem;
  logic flush_decode, flush_execute, flush_mem, flush_wb;
  logic pc_redirect, muldiv_go, bus_error;
  logic [CNT_W-1:0] perf_stall_cycles;

  int compared = 0;
  int mismatched = 0;
  logic [CNT_W-1:0] perf_model = '0;
  logic [10:0] exp_q[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  pipeline_control #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rs1_addr_decode(rs1_addr_decode), .rs2_addr_decode(rs2_addr_decode),
    .rs1_used_decode(rs1_used_decode), .rs2_used_decode(rs2_used_decode),
    .rd_addr_execute(rd_addr_execute), .mem_read_execute(mem_read_execute),
    .branch_taken_execute(branch_taken_execute), .muldiv_req_execute(muldiv_req_execute),
    .muldiv_done(muldiv_done), .dmem_req_mem(dmem_req_mem), .dmem_ack(dmem_ack),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode), .stall_execute(stall_execute),
    .stall_mem(stall_mem), .flush_decode(flush_decode), .flush_execute(flush_execute),
    .flush_mem(flush_mem), .flush_wb(flush_wb), .pc_redirect(pc_redirect),
    .muldiv_go(muldiv_go), .bus_error(bus_error), .perf_stall_cycles(perf_stall_cycles)
  );

  function automatic vec_t mk(logic r, logic [4:0] a1, logic b1, logic [4:0] a2, logic b2,
                              logic [4:0] d, logic l, logic b, logic mq, logic md,
                              logic dq, logic dk, logic [10:0] e);
    vec_t t;
    t.rst = r; t.rs1 = a1; t.u1 = b1; t.rs2 = a2; t.u2 = b2; t.rd = d; t.lr = l;
    t.br = b; t.mreq = mq; t.mdone = md; t.dreq = dq; t.dack = dk; t.exp = e;
    return t;
  endfunction

  // Shorthand for vectors with no decode/execute register traffic.
  function automatic vec_t ctl(logic r, logic mq, logic md, logic dq, logic dk, logic [10:0] e);
    return mk(r, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, mq, md, dq, dk, e);
  endfunction

  task automatic apply(input vec_t t, input int idx);
    logic [10:0] act, exp;
    rst = t.rst;
    rs1_addr_decode = t.rs1; rs1_used_decode = t.u1;
    rs2_addr_decode = t.rs2; rs2_used_decode = t.u2;
    rd_addr_execute = t.rd;  mem_read_execute = t.lr;
    branch_taken_execute = t.br;
    muldiv_req_execute = t.mreq; muldiv_done = t.mdone;
    dmem_req_mem = t.dreq; dmem_ack = t.dack;
    exp_q.push_back(t.exp);
    @(negedge clk);
    act = {stall_fetch, stall_decode, stall_execute, stall_mem,
           flush_decode, flush_execute, flush_mem, flush_wb,
           pc_redirect, muldiv_go, bus_error};
    exp = exp_q.pop_front();
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL outputs vec %0d: got %b want %b (SF SD SE SM FD FE FM FW PR GO BE)", idx, act, exp);
    end
    compared++;
    if (perf_stall_cycles !== perf_model) begin
      mismatched++;
      $display("FAIL perf vec %0d: got %0d want %0d", idx, perf_stall_cycles, perf_model);
    end
    if (t.rst) perf_model = '0;
    else if (exp[10] && !(&perf_model)) perf_model = perf_model + 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rs1_addr_decode = '0; rs2_addr_decode = '0; rd_addr_execute = '0;
    rs1_used_decode = 1'b0; rs2_used_decode = 1'b0; mem_read_execute = 1'b0;
    branch_taken_execute = 1'b0; muldiv_req_execute = 1'b0; muldiv_done = 1'b0;
    dmem_req_mem = 1'b0; dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state and load-use cases
    vecs.push_back(ctl(0, 0, 0, 0, 0, E_NONE));
    vecs.push_back(mk(0, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 0, 0, 0, 0, E_LU));
    vecs.push_back(ctl(0, 0, 0, 0, 0, E_NONE));
    vecs.push_back(mk(0, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 0, 0, 0, 0, E_NONE));
    vecs.push_back(mk(0, 5'd3, 1, 5'd7, 1, 5'd7, 1, 0, 0, 0, 0, 0, E_LU));
    vecs.push_back(mk(0, 5'd3, 1, 5'd7, 0, 5'd7, 1, 0, 0, 0, 0, 0, E_NONE));
    vecs.push_back(mk(0, 5'd7, 1, 5'd7, 0, 5'd7, 0, 0, 0, 0, 0, 0, E_NONE));
    // Branch overrides load-use; branch alone
    vecs.push_back(mk(0, 5'd5, 1, 5'd0, 0, 5'd5, 1, 1, 0, 0, 0, 0, E_BR));
    vecs.push_back(mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 0, 0, 0, E_BR));
    // Mul/div: 4-cycle op, then back-to-back op, then same-cycle done
    vecs.push_back(ctl(0, 1, 0, 0, 0, E_MDGO));
    vecs.push_back(ctl(0, 1, 0, 0, 0, E_MD));
    vecs.push_back(ctl(0, 1, 0, 0, 0, E_MD));
    vecs.push_back(ctl(0, 1, 1, 0, 0, E_NONE));
    vecs.push_back(ctl(0, 1, 0, 0, 0, E_MDGO));
    vecs.push_back(ctl(0, 1, 1, 0, 0, E_NONE));
    vecs.push_back(ctl(0, 1, 1, 0, 0, E_GO));
    vecs.push_back(ctl(0, 0, 0, 0, 0, E_NONE));
    // Mem wait of 3 cycles (first one also carries a load-use), then zero-wait access
    vecs.push_back(mk(0, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0, 0, 0, 1, 0, E_MEM));
    vecs.push_back(ctl(0, 0, 0, 1, 0, E_MEM));
    vecs.push_back(ctl(0, 0, 0, 1, 0, E_MEM));
    vecs.push_back(ctl(0, 0, 0, 1, 1, E_NONE));
    vecs.push_back(ctl(0, 0, 0, 0, 0, E_NONE));
    vecs.push_back(ctl(0, 0, 0, 1, 1, E_NONE));
    // Mul/div request held off while MEM is frozen
    vecs.push_back(ctl(0, 1, 0, 1, 0, E_MEM));
    vecs.push_back(ctl(0, 0, 0, 1, 1, E_NONE));
    // Mem stall during BUSY; done consumed under the stall
    vecs.push_back(ctl(0, 1, 0, 0, 0, E_MDGO));
    vecs.push_back(ctl(0, 1, 0, 1, 0, E_MEM));
    vecs.push_back(ctl(0, 1, 1, 1, 0, E_MEM));
    vecs.push_back(ctl(0, 0, 0, 1, 1, E_NONE));
    vecs.push_back(ctl(0, 1, 0, 0, 0, E_MDGO));
    // md stall beats branch; reset mid-BUSY
    vecs.push_back(mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 0, 0, 0, E_MD));
    vecs.push_back(ctl(1, 1, 0, 0, 0, E_MD));
    vecs.push_back(ctl(0, 0, 0, 0, 0, E_NONE));
    vecs.push_back(ctl(0, 0, 0, 0, 0, E_NONE));

    // Timeout: 15 stall cycles, release on the 16th, error pulse next, counter restarts
    for (int i = 0; i < 15; i++) vecs.push_back(ctl(0, 0, 0, 1, 0, E_MEM));
    vecs.push_back(ctl(0, 0, 0, 1, 0, E_NONE));
    vecs.push_back(ctl(0, 0, 0, 1, 0, E_MEM | E_BE));
    for (int i = 0; i < 13; i++) vecs.push_back(ctl(0, 0, 0, 1, 0, E_MEM));
    vecs.push_back(ctl(0, 0, 0, 1, 1, E_NONE));
    vecs.push_back(ctl(0, 0, 0, 0, 0, E_NONE));

    // Reset in the timeout cycle suppresses the error pulse
    for (int i = 0; i < 15; i++) vecs.push_back(ctl(0, 0, 0, 1, 0, E_MEM));
    vecs.push_back(ctl(1, 0, 0, 1, 0, E_NONE));
    vecs.push_back(ctl(0, 0, 0, 0, 0, E_NONE));
    // Reset mid-wait abandons the wait
    vecs.push_back(ctl(0, 0, 0, 1, 0, E_MEM));
    vecs.push_back(ctl(0, 0, 0, 1, 0, E_MEM));
    vecs.push_back(ctl(1, 0, 0, 1, 0, E_MEM));
    vecs.push_back(ctl(0, 0, 0, 0, 0, E_NONE));
    vecs.push_back(ctl(0, 0, 0, 0, 0, E_NONE));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
